// File: rtl/raspi_rx_pkg.sv
// Shared constants, queue entry type and echo transform for the RasPi parallel-bus receiver.
// Echo behaviour is selected by RASPI_RX_ECHO_EN in raspi_word_rx.
package raspi_rx_pkg;

    localparam logic [3:0] MODE_ECHO = 4'd0;
    localparam logic [3:0] MODE_LOAD = 4'd1;
    localparam int         CMD_BIT   = 8;
    localparam int         WR_ADDR_W = 16;

    typedef struct packed {
        logic [WR_ADDR_W-1:0] addr;
        logic [31:0]          data;
    } wr_entry_t;

    // Readback transform; every intermediate result is kept at 9 bits on purpose.
    function automatic logic [8:0] echo_xform(input logic [8:0] din);
        logic [8:0] shifted;
        shifted = din << 5;
        return (shifted + din) ^ 9'd7;
    endfunction

endpackage

// File: rtl/raspi_rx_fifo.sv
// Synchronous write queue with valid/ready pop, drop-on-full push and same-cycle push+pop.
// Reset is synchronous, active-low.
module raspi_rx_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 48
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    output logic             push_drop_o,
    output logic             valid_o,
    input  logic             ready_i,
    output logic [WIDTH-1:0] pop_data_o
);

    localparam int PTR_W = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;
    logic             full, empty, pop, push_ok;

    assign empty   = (count_q == '0);
    assign full    = (count_q == (PTR_W+1)'(DEPTH));
    assign pop     = !empty && ready_i;
    // A full queue still accepts a push when the head leaves in the same cycle.
    assign push_ok = push_i && (!full || pop);

    assign valid_o     = !empty;
    assign pop_data_o  = mem_q[rd_ptr_q];
    assign push_drop_o = push_i && !push_ok;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_ok) wr_ptr_d = wr_ptr_q + PTR_W'(1);
        if (pop)     rd_ptr_d = rd_ptr_q + PTR_W'(1);
        case ({push_ok, pop})
            2'b10:   count_d = count_q + (PTR_W+1)'(1);
            2'b01:   count_d = count_q - (PTR_W+1)'(1);
            default: count_d = count_q;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: storage is deliberately not reset; the count guards every read, and this keeps it RAM-friendly.
    always_ff @(posedge clk_i) begin
        if (push_ok) mem_q[wr_ptr_q] <= push_data_i;
    end

endmodule

// File: rtl/raspi_word_rx.sv
// RasPi 9-bit parallel bus receiver: oversampled strobe, command decode, little-endian word load into a write queue.
// Define RASPI_RX_ECHO_EN to enable mode-0 echo readback and bus output enable; otherwise both are tied low.
module raspi_word_rx
    import raspi_rx_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int ADDR_W      = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic              CLK12MHZ,
    input  logic              resetn,
    input  logic              raspi_clk,
    input  logic              raspi_dir,
    input  logic [8:0]        raspi_din,
    output logic [8:0]        raspi_dout,
    output logic              raspi_oe,
    output logic [3:0]        mode,
    output logic              load_active,
    output logic              wr_valid,
    input  logic              wr_ready,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              overflow
);

    logic [SYNC_STAGES-1:0]      clk_sync_q;
    logic [SYNC_STAGES-1:0]      dir_sync_q;
    logic [SYNC_STAGES-1:0][8:0] din_sync_q;
    logic                        clk_prev_q;

    logic                        clk_s, dir_s;
    logic [8:0]                  din_s;
    logic                        bus_event, cmd_event, data_event;

    logic [3:0]                  mode_q, mode_d;
    logic [ADDR_W-1:0]           addr_q, addr_d;
    logic [31:0]                 word_q, word_d;
    logic [1:0]                  byte_cnt_q, byte_cnt_d;
    logic                        push_q, push_d;
    logic                        overflow_q, overflow_d;
    logic                        fifo_drop;
    logic [ADDR_W+31:0]          fifo_head;

    assign clk_s = clk_sync_q[SYNC_STAGES-1];
    assign dir_s = dir_sync_q[SYNC_STAGES-1];
    assign din_s = din_sync_q[SYNC_STAGES-1];

    assign bus_event  = clk_s && !clk_prev_q;
    assign cmd_event  = bus_event && dir_s && din_s[CMD_BIT];
    assign data_event = bus_event && dir_s && !din_s[CMD_BIT];

    // dir resets to "RasPi drives" so the bus output enable stays off until real dir arrives.
    always_ff @(posedge CLK12MHZ) begin
        if (!resetn) begin
            clk_sync_q <= '0;
            dir_sync_q <= '1;
            din_sync_q <= '0;
            clk_prev_q <= 1'b0;
        end else begin
            clk_sync_q <= {clk_sync_q[SYNC_STAGES-2:0], raspi_clk};
            dir_sync_q <= {dir_sync_q[SYNC_STAGES-2:0], raspi_dir};
            din_sync_q <= {din_sync_q[SYNC_STAGES-2:0], raspi_din};
            clk_prev_q <= clk_s;
        end
    end

`ifdef RASPI_RX_ECHO_EN
    logic [8:0] dout_q, dout_d;
`endif

    always_comb begin
        mode_d     = mode_q;
        addr_d     = addr_q;
        word_d     = word_q;
        byte_cnt_d = byte_cnt_q;
        push_d     = 1'b0;
        overflow_d = overflow_q || fifo_drop;
`ifdef RASPI_RX_ECHO_EN
        dout_d     = dout_q;
`endif
        if (cmd_event) begin
            mode_d     = din_s[3:0];
            addr_d     = '1;
            word_d     = '0;
            byte_cnt_d = '0;
            overflow_d = 1'b0;
`ifdef RASPI_RX_ECHO_EN
            dout_d     = '0;
`endif
        end else if (data_event) begin
            if (mode_q == MODE_LOAD) begin
                word_d     = {din_s[7:0], word_q[31:8]};
                byte_cnt_d = byte_cnt_q + 2'd1;
                // The all-ones start address wraps so the first completed word lands at 0.
                if (byte_cnt_q == 2'd3) begin
                    addr_d = addr_q + ADDR_W'(1);
                    push_d = 1'b1;
                end
            end
`ifdef RASPI_RX_ECHO_EN
            else if (mode_q == MODE_ECHO) begin
                dout_d = echo_xform(din_s);
            end
`endif
        end
    end

    always_ff @(posedge CLK12MHZ) begin
        if (!resetn) begin
            mode_q     <= MODE_ECHO;
            addr_q     <= '1;
            word_q     <= '0;
            byte_cnt_q <= '0;
            push_q     <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            mode_q     <= mode_d;
            addr_q     <= addr_d;
            word_q     <= word_d;
            byte_cnt_q <= byte_cnt_d;
            push_q     <= push_d;
            overflow_q <= overflow_d;
        end
    end

`ifdef RASPI_RX_ECHO_EN
    always_ff @(posedge CLK12MHZ) begin
        if (!resetn) dout_q <= '0;
        else         dout_q <= dout_d;
    end

    assign raspi_dout = dout_q;
    assign raspi_oe   = !dir_s;
`else
    assign raspi_dout = '0;
    assign raspi_oe   = 1'b0;
`endif

    // The push is issued one cycle after the last byte, once addr_q and word_q hold the finished word.
    raspi_rx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (ADDR_W + 32)
    ) u_fifo (
        .clk_i       (CLK12MHZ),
        .rst_n_i     (resetn),
        .push_i      (push_q),
        .push_data_i ({addr_q, word_q}),
        .push_drop_o (fifo_drop),
        .valid_o     (wr_valid),
        .ready_i     (wr_ready),
        .pop_data_o  (fifo_head)
    );

    assign wr_addr     = fifo_head[ADDR_W+31:32];
    assign wr_data     = fifo_head[31:0];
    assign mode        = mode_q;
    assign load_active = (mode_q == MODE_LOAD);
    assign overflow    = overflow_q;

endmodule

// File: tb/tb_raspi_word_rx.sv
// Scoreboard bench for raspi_word_rx: stimulus queues expected writes, a monitor pops them on each handshake.
module tb_raspi_word_rx;
    import raspi_rx_pkg::*;

    localparam int HALF = 6;

    logic        clk = 1'b0;
    logic        resetn;
    logic        raspi_clk;
    logic        raspi_dir;
    logic [8:0]  raspi_din;
    logic [8:0]  raspi_dout;
    logic        raspi_oe;
    logic [3:0]  mode;
    logic        load_active;
    logic        wr_valid;
    logic        wr_ready;
    logic [15:0] wr_addr;
    logic [31:0] wr_data;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    wr_entry_t sb[$];

    raspi_word_rx dut (
        .CLK12MHZ    (clk),
        .resetn      (resetn),
        .raspi_clk   (raspi_clk),
        .raspi_dir   (raspi_dir),
        .raspi_din   (raspi_din),
        .raspi_dout  (raspi_dout),
        .raspi_oe    (raspi_oe),
        .mode        (mode),
        .load_active (load_active),
        .wr_valid    (wr_valid),
        .wr_ready    (wr_ready),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .overflow    (overflow)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic bus_xfer(input logic [8:0] d);
        raspi_din = d;
        raspi_dir = 1'b1;
        tick(HALF);
        raspi_clk = 1'b1;
        tick(HALF);
        raspi_clk = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        for (int i = 0; i < 4; i++) bus_xfer({1'b0, w[8*i +: 8]});
    endtask

    task automatic expect_write(input logic [15:0] a, input logic [31:0] d);
        wr_entry_t e;
        e.addr = a;
        e.data = d;
        sb.push_back(e);
    endtask

    task automatic wait_drain();
        int n = 0;
        while (sb.size() != 0 && n < 300) begin
            tick(1);
            n++;
        end
        check("queue_drained", 64'(sb.size()), 64'd0);
    endtask

    // Monitor: compare the head against the scoreboard on every accepted handshake.
    initial begin
        wr_entry_t e;
        forever begin
            @(negedge clk);
            if (resetn && wr_valid && wr_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_write", 64'(wr_addr), 64'hFFFF_FFFF);
                end else begin
                    e = sb.pop_front();
                    check("wr_addr", 64'(wr_addr), 64'(e.addr));
                    check("wr_data", 64'(wr_data), 64'(e.data));
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        resetn    = 1'b0;
        raspi_clk = 1'b0;
        raspi_dir = 1'b1;
        raspi_din = '0;
        wr_ready  = 1'b1;
        tick(3);
        resetn = 1'b1;
        tick(2);
        check("rst_mode", 64'(mode), 64'd0);
        check("rst_load_active", 64'(load_active), 64'd0);
        check("rst_wr_valid", 64'(wr_valid), 64'd0);
        check("rst_overflow", 64'(overflow), 64'd0);
        check("rst_dout", 64'(raspi_dout), 64'd0);
        check("rst_oe", 64'(raspi_oe), 64'd0);

        // First load word lands at address 0.
        bus_xfer(9'h101);
        check("load_mode", 64'(mode), 64'd1);
        check("load_active", 64'(load_active), 64'd1);
        expect_write(16'd0, 32'h4433_2211);
        send_word(32'h4433_2211);
        wait_drain();

        // Second word; nothing may appear after only three bytes.
        expect_write(16'd1, 32'hDDCC_BBAA);
        bus_xfer(9'h0AA);
        bus_xfer(9'h0BB);
        bus_xfer(9'h0CC);
        tick(10);
        check("no_valid_3_bytes", 64'(wr_valid), 64'd0);
        bus_xfer(9'h0DD);
        wait_drain();

        // Stalled consumer: four words fit, the fifth is dropped.
        wr_ready = 1'b0;
        bus_xfer(9'h101);
        for (int i = 0; i < 5; i++) begin
            if (i < 4) expect_write(16'(i), 32'h1000_0000 + 32'(i));
            send_word(32'h1000_0000 + 32'(i));
        end
        tick(4);
        check("ovf_set", 64'(overflow), 64'd1);
        check("stall_valid", 64'(wr_valid), 64'd1);
        check("stall_addr", 64'(wr_addr), 64'd0);
        check("stall_data", 64'(wr_data), 64'h1000_0000);
        tick(7);
        check("stall_data_stable", 64'(wr_data), 64'h1000_0000);
        wr_ready = 1'b1;
        wait_drain();
        check("ovf_sticky", 64'(overflow), 64'd1);
        bus_xfer(9'h101);
        check("ovf_cleared", 64'(overflow), 64'd0);

        // A command mid-word discards the partial word.
        bus_xfer(9'h055);
        bus_xfer(9'h066);
        bus_xfer(9'h101);
        expect_write(16'd0, 32'h0403_0201);
        send_word(32'h0403_0201);
        wait_drain();

        // Echo mode.
        bus_xfer(9'h100);
        check("echo_mode", 64'(mode), 64'd0);
        check("echo_load_active", 64'(load_active), 64'd0);
        bus_xfer(9'h003);
`ifdef RASPI_RX_ECHO_EN
        check("echo_03", 64'(raspi_dout), 64'h064);
        bus_xfer(9'h0FF);
        check("echo_ff", 64'(raspi_dout), 64'h0D8);
        raspi_dir = 1'b0;
        tick(6);
        check("oe_dir0", 64'(raspi_oe), 64'd1);
        raspi_dir = 1'b1;
        tick(6);
        check("oe_dir1", 64'(raspi_oe), 64'd0);
        bus_xfer(9'h100);
        check("echo_cmd_clears", 64'(raspi_dout), 64'd0);
`else
        check("echo_off_dout", 64'(raspi_dout), 64'd0);
        raspi_dir = 1'b0;
        tick(6);
        check("echo_off_oe", 64'(raspi_oe), 64'd0);
        raspi_dir = 1'b1;
        tick(6);
`endif

        // One-cycle reset with two words queued discards everything.
        wr_ready = 1'b0;
        bus_xfer(9'h101);
        send_word(32'h1111_1111);
        send_word(32'h2222_2222);
        tick(3);
        check("pre_rst_valid", 64'(wr_valid), 64'd1);
        resetn = 1'b0;
        tick(1);
        resetn = 1'b1;
        tick(1);
        check("post_rst_valid", 64'(wr_valid), 64'd0);
        check("post_rst_mode", 64'(mode), 64'd0);
        check("post_rst_overflow", 64'(overflow), 64'd0);
        wr_ready = 1'b1;
        bus_xfer(9'h101);
        expect_write(16'd0, 32'hCAFE_F00D);
        send_word(32'hCAFE_F00D);
        wait_drain();

        tick(5);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
